// File: rtl/instruction_fetch.sv
// Instruction fetch: issues in-order memory requests under a credit budget, tags each with
// its PC, and buffers responses in a FIFO towards decode. A redirect (flush) empties the
// buffers and discards responses still owed by the memory.
// Optional feature macro: IFETCH_MISALIGN_CHECK_EN (misaligned PCs become fault entries).
module instruction_fetch #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] pc_i,
   input  logic                  pc_valid_i,
   output logic                  pc_ready_o,
   input  logic                  flush_i,
   output logic                  imem_req_valid_o,
   input  logic                  imem_req_ready_i,
   output logic [ADDR_WIDTH-1:0] imem_req_addr_o,
   input  logic                  imem_rsp_valid_i,
   input  logic [31:0]           imem_rsp_data_i,
   output logic                  instr_valid_o,
   input  logic                  instr_ready_i,
   output logic [31:0]           instr_o,
   output logic [ADDR_WIDTH-1:0] instr_pc_o,
   output logic                  instr_fault_o
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   // Drop counter may accumulate across back-to-back redirects, so give it headroom.
   localparam int unsigned DW = CW + 3;

   logic [31:0]           r_fifo_data [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];
   logic [PW-1:0]         r_fifo_wr, r_fifo_rd;
   logic [CW-1:0]         r_fifo_cnt;
   logic [ADDR_WIDTH-1:0] r_tag       [FIFO_DEPTH];
   logic [PW-1:0]         r_tag_wr, r_tag_rd;
   logic [CW-1:0]         r_tag_cnt;
   logic [DW-1:0]         r_drop;

   logic [CW:0]           w_used;
   logic                  w_credit;
   logic                  w_misalign;
   logic                  w_block;
   logic                  w_flt_drain;
   logic [CW-1:0]         w_outstanding;
   logic                  w_can_issue;
   logic                  w_tag_push;
   logic                  w_rsp_drop;
   logic                  w_rsp_keep;
   logic                  w_push;
   logic                  w_pop;
   logic [DW-1:0]         w_inflight;
   logic [DW-1:0]         w_drop_flush;

`ifdef IFETCH_MISALIGN_CHECK_EN
   logic r_flt_pend;
   logic r_fifo_flt [FIFO_DEPTH];

   assign w_misalign    = (pc_i[1:0] != 2'b00);
   // A pending fault sits at the tail of the tag queue; hold new fetches until it drains so
   // no memory response can ever be owed to an entry behind it.
   assign w_block       = r_flt_pend;
   assign w_flt_drain   = r_flt_pend & (r_tag_cnt == CW'(1));
   assign w_outstanding = r_tag_cnt - CW'(r_flt_pend);
   assign instr_fault_o = instr_valid_o & r_fifo_flt[r_fifo_rd];

   // Track the single pending fault entry.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         r_flt_pend <= 1'b0;
      end else if (w_can_issue && w_misalign) begin
         r_flt_pend <= 1'b1;
      end else if (w_flt_drain) begin
         r_flt_pend <= 1'b0;
      end
   end

   // Fault flag storage alongside each FIFO entry.
   always_ff @(posedge clk) begin
      if (!rst && !flush_i && w_push) begin
         r_fifo_flt[r_fifo_wr] <= w_flt_drain;
      end
   end
`else
   assign w_misalign    = 1'b0;
   assign w_block       = 1'b0;
   assign w_flt_drain   = 1'b0;
   assign w_outstanding = r_tag_cnt;
   assign instr_fault_o = 1'b0;
`endif

   assign w_used      = {1'b0, r_fifo_cnt} + {1'b0, r_tag_cnt};
   assign w_credit    = (32'(w_used) < FIFO_DEPTH);
   assign w_can_issue = !rst & pc_valid_i & w_credit & !flush_i & !w_block;

   assign imem_req_valid_o = w_can_issue & !w_misalign;
   assign imem_req_addr_o  = pc_i;
   assign pc_ready_o       = (imem_req_valid_o & imem_req_ready_i) | (w_can_issue & w_misalign);
   assign w_tag_push       = pc_ready_o;

   // Responses first repay the drop debt; with nothing owed at all they are ignored.
   assign w_rsp_drop = imem_rsp_valid_i & (r_drop != '0);
   assign w_rsp_keep = imem_rsp_valid_i & (r_drop == '0) & (w_outstanding != '0);
   assign w_push     = w_rsp_keep | w_flt_drain;
   assign w_pop      = instr_valid_o & instr_ready_i;

   assign w_inflight   = r_drop + DW'(w_outstanding);
   assign w_drop_flush = w_inflight - DW'(imem_rsp_valid_i && (w_inflight != '0));

   assign instr_valid_o = (r_fifo_cnt != '0);
   assign instr_o       = instr_valid_o ? r_fifo_data[r_fifo_rd] : 32'h0;
   assign instr_pc_o    = instr_valid_o ? r_fifo_pc[r_fifo_rd] : '0;

   // Pointers and counters; a flush overrides any push, pop or request in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fifo_wr  <= '0;
         r_fifo_rd  <= '0;
         r_fifo_cnt <= '0;
         r_tag_wr   <= '0;
         r_tag_rd   <= '0;
         r_tag_cnt  <= '0;
         r_drop     <= '0;
      end else if (flush_i) begin
         r_fifo_wr  <= '0;
         r_fifo_rd  <= '0;
         r_fifo_cnt <= '0;
         r_tag_wr   <= '0;
         r_tag_rd   <= '0;
         r_tag_cnt  <= '0;
         r_drop     <= w_drop_flush;
      end else begin
         if (w_push)     r_fifo_wr <= r_fifo_wr + PW'(1);
         if (w_pop)      r_fifo_rd <= r_fifo_rd + PW'(1);
         if (w_push && !w_pop)      r_fifo_cnt <= r_fifo_cnt + CW'(1);
         else if (!w_push && w_pop) r_fifo_cnt <= r_fifo_cnt - CW'(1);
         if (w_tag_push) r_tag_wr <= r_tag_wr + PW'(1);
         if (w_push)     r_tag_rd <= r_tag_rd + PW'(1);
         if (w_tag_push && !w_push)      r_tag_cnt <= r_tag_cnt + CW'(1);
         else if (!w_tag_push && w_push) r_tag_cnt <= r_tag_cnt - CW'(1);
         if (w_rsp_drop) r_drop <= r_drop - DW'(1);
      end
   end

   // Tag and FIFO payload storage (no reset needed; validity lives in the counters).
   always_ff @(posedge clk) begin
      if (!rst && !flush_i) begin
         if (w_tag_push) r_tag[r_tag_wr] <= pc_i;
         if (w_push) begin
            r_fifo_data[r_fifo_wr] <= w_rsp_keep ? imem_rsp_data_i : 32'h0;
            r_fifo_pc[r_fifo_wr]   <= r_tag[r_tag_rd];
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch (default build, FIFO_DEPTH=2): directed
// scenarios with literal expectations, then randomized traffic against a transaction model.
module tb_instruction_fetch;
   localparam int unsigned AW    = 32;
   localparam int unsigned DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] pc_i = '0;
   logic          pc_valid_i = 1'b0;
   logic          pc_ready_o;
   logic          flush_i = 1'b0;
   logic          imem_req_valid_o;
   logic          imem_req_ready_i = 1'b1;
   logic [AW-1:0] imem_req_addr_o;
   logic          imem_rsp_valid_i = 1'b0;
   logic [31:0]   imem_rsp_data_i = '0;
   logic          instr_valid_o;
   logic          instr_ready_i = 1'b1;
   logic [31:0]   instr_o;
   logic [AW-1:0] instr_pc_o;
   logic          instr_fault_o;

   instruction_fetch #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst              (rst),
      .pc_i             (pc_i),
      .pc_valid_i       (pc_valid_i),
      .pc_ready_o       (pc_ready_o),
      .flush_i          (flush_i),
      .imem_req_valid_o (imem_req_valid_o),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_req_addr_o  (imem_req_addr_o),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .instr_valid_o    (instr_valid_o),
      .instr_ready_i    (instr_ready_i),
      .instr_o          (instr_o),
      .instr_pc_o       (instr_pc_o),
      .instr_fault_o    (instr_fault_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'hC3C33C3C;
   endfunction

   // Memory: in-order responses, each at least one cycle after its request.
   typedef struct { logic [31:0] addr; int gen; int due; } mreq_t;
   mreq_t mem_q[$];
   int cyc = 0;
   int lat_fixed = 0;
   int lat_rand = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
      #1;
      imem_rsp_valid_i = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      imem_rsp_data_i  = imem_rsp_valid_i ? mem_word(mem_q[0].addr) : 32'h0;
   end

   // Model: exp_q holds the PCs of live fetches (issued since the last flush/reset and not
   // yet consumed by decode) in issue order; 'arrived' counts how many of the oldest ones
   // have their data back. Responses stamped with an older generation are dead.
   logic [31:0] exp_q[$];
   int arrived = 0;
   int gen = 0;

   initial forever begin
      @(negedge clk);
      begin : chk_cycle
         mreq_t m;
         mreq_t nm;
         bit    keep;
         bit    exp_req;
         keep = 1'b0;
         if (imem_rsp_valid_i) begin
            m = mem_q.pop_front();
            keep = !rst && !flush_i && (m.gen == gen);
         end
         if (rst) begin
            if (cyc > 0) begin
               chk("rst_instr_valid", instr_valid_o, 0);
               chk("rst_instr", instr_o, 0);
               chk("rst_instr_pc", instr_pc_o, 0);
               chk("rst_fault", instr_fault_o, 0);
               chk("rst_req_valid", imem_req_valid_o, 0);
               chk("rst_pc_ready", pc_ready_o, 0);
            end
            exp_q.delete();
            arrived = 0;
            gen++;
         end else begin
            exp_req = pc_valid_i && !flush_i && (exp_q.size() < DEPTH);
            chk("imem_req_valid", imem_req_valid_o, exp_req);
            chk("pc_ready", pc_ready_o, exp_req && imem_req_ready_i);
            if (imem_req_valid_o) chk("imem_req_addr", imem_req_addr_o, pc_i);
            chk("instr_valid", instr_valid_o, arrived > 0);
            if (arrived > 0) begin
               chk("instr_pc", instr_pc_o, exp_q[0]);
               chk("instr_data", instr_o, mem_word(exp_q[0]));
               chk("instr_fault", instr_fault_o, 0);
            end
            if (flush_i) begin
               exp_q.delete();
               arrived = 0;
               gen++;
            end else begin
               if (arrived > 0 && instr_ready_i) begin
                  void'(exp_q.pop_front());
                  arrived--;
               end
               if (keep) arrived++;
               if (exp_req && imem_req_ready_i) exp_q.push_back(pc_i);
            end
         end
         if (imem_req_valid_o && imem_req_ready_i) begin
            nm.addr = imem_req_addr_o;
            nm.gen  = gen;
            nm.due  = cyc + 1 + lat_fixed + int'($urandom_range(0, lat_rand));
            mem_q.push_back(nm);
         end
      end
   end

   logic [31:0] got_q[$];
   logic        flt_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc_end();
      @(negedge clk);
      if (instr_valid_o && instr_ready_i) begin
         got_q.push_back(instr_pc_o);
         flt_q.push_back(instr_fault_o);
      end
   endtask

   task automatic drain(input int n);
      pc_valid_i    = 1'b0;
      flush_i       = 1'b0;
      instr_ready_i = 1'b1;
      for (int i = 0; i < n; i++) begin
         cyc_end();
         tick();
      end
   endtask

   logic [31:0] pcs [4];
   int rq [3];
   int oc [3];
   logic [31:0] op [3];

   initial begin
      int k;
      int n;
      int vis;
      pcs = '{32'h0, 32'h4, 32'h8, 32'h0};
      // Reset with a fetch offered: nothing may issue.
      pc_valid_i = 1'b1;
      pc_i       = 32'h1000;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      pc_valid_i = 1'b0;

      // Zero-wait memory, decode always ready: 0x0, 0x4, 0x8.
      k = 0;
      n = 0;
      for (int i = 0; i < 3; i++) begin rq[i] = -1; oc[i] = -1; op[i] = '1; end
      for (int i = 0; i < 8; i++) begin
         tick();
         pc_valid_i = (k < 3);
         pc_i       = pcs[k];
         @(negedge clk);
         if (pc_ready_o) begin
            if (k < 3) rq[k] = i;
            k++;
         end
         if (instr_valid_o && instr_ready_i && n < 3) begin
            op[n] = instr_pc_o;
            oc[n] = i;
            n++;
         end
      end
      // Depth 2 leaves no credit in the third cycle, so 0x8 issues one cycle late.
      chk("seq_req_cyc0", rq[0], 0);
      chk("seq_req_cyc1", rq[1], 1);
      chk("seq_req_cyc2", rq[2], 3);
      chk("seq_out_cyc0", oc[0], 2);
      chk("seq_out_cyc1", oc[1], 3);
      chk("seq_out_cyc2", oc[2], 5);
      chk("seq_out_pc0", op[0], 32'h0);
      chk("seq_out_pc1", op[1], 32'h4);
      chk("seq_out_pc2", op[2], 32'h8);
      tick();
      drain(4);

      // Decode stalled: two accepted, then blocked; one pop frees exactly one request.
      instr_ready_i = 1'b0;
      k = 0;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) tick();
         pc_valid_i = 1'b1;
         pc_i       = 32'h10 + 32'(4 * k);
         @(negedge clk);
         if (pc_ready_o) k++;
      end
      chk("stall_accepted", k, 2);
      chk("stall_req_valid", imem_req_valid_o, 0);
      chk("stall_pc_ready", pc_ready_o, 0);
      tick();
      instr_ready_i = 1'b1;
      pc_i          = 32'h10 + 32'(4 * k);
      @(negedge clk);
      if (pc_ready_o) k++;
      for (int i = 0; i < 4; i++) begin
         tick();
         instr_ready_i = 1'b0;
         pc_i          = 32'h10 + 32'(4 * k);
         @(negedge clk);
         if (pc_ready_o) k++;
      end
      chk("stall_one_more", k, 3);
      tick();
      drain(8);

      // Two outstanding, flush, then 0x100: only 0x100 comes out.
      lat_fixed = 3;
      got_q.delete();
      pc_valid_i = 1'b1; pc_i = 32'h40; cyc_end();
      chk("flush_req0", pc_ready_o, 1);
      tick(); pc_i = 32'h44; cyc_end();
      chk("flush_req1", pc_ready_o, 1);
      tick(); pc_valid_i = 1'b0; flush_i = 1'b1; cyc_end();
      tick(); flush_i = 1'b0; pc_valid_i = 1'b1; pc_i = 32'h100; cyc_end();
      chk("flush_new_req", pc_ready_o, 1);
      tick();
      drain(14);
      chk("flush_out_count", got_q.size(), 1);
      if (got_q.size() > 0) chk("flush_out_pc", got_q[0], 32'h100);

      // Flush coinciding with a response and a pop.
      lat_fixed = 1;
      pc_valid_i = 1'b1; pc_i = 32'h20; cyc_end();
      tick(); pc_i = 32'h24; cyc_end();
      tick(); pc_valid_i = 1'b0; cyc_end();
      tick(); flush_i = 1'b1; cyc_end();
      chk("fpop_valid", instr_valid_o, 1);
      chk("fpop_pc", instr_pc_o, 32'h20);
      got_q.delete();
      tick(); flush_i = 1'b0; pc_valid_i = 1'b1; pc_i = 32'h300; cyc_end();
      chk("fpop_empty", instr_valid_o, 0);
      chk("fpop_new_req", pc_ready_o, 1);
      tick();
      drain(10);
      chk("fpop_out_count", got_q.size(), 1);
      if (got_q.size() > 0) chk("fpop_out_pc", got_q[0], 32'h300);

      // Misaligned PC without the check feature: plain request, no fault.
      lat_fixed = 0;
      got_q.delete();
      flt_q.delete();
      pc_valid_i = 1'b1; pc_i = 32'h6; cyc_end();
      chk("mis_req_valid", imem_req_valid_o, 1);
      chk("mis_req_addr", imem_req_addr_o, 32'h6);
      tick();
      drain(5);
      chk("mis_out_count", got_q.size(), 1);
      if (got_q.size() > 0) begin
         chk("mis_out_pc", got_q[0], 32'h6);
         chk("mis_out_fault", flt_q[0], 0);
      end

      // Reset with two outstanding; late responses must be ignored.
      lat_fixed = 3;
      pc_valid_i = 1'b1; pc_i = 32'h80; cyc_end();
      tick(); pc_i = 32'h84; cyc_end();
      tick(); pc_valid_i = 1'b0; rst = 1'b1; cyc_end();
      tick(); cyc_end();
      tick(); rst = 1'b0;
      vis = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (instr_valid_o) vis++;
         tick();
      end
      chk("rst_late_rsp_valid", vis, 0);
      lat_fixed = 0;
      got_q.delete();
      pc_valid_i = 1'b1; pc_i = 32'h200; cyc_end();
      chk("rst_post_req", pc_ready_o, 1);
      tick();
      drain(5);
      chk("rst_post_count", got_q.size(), 1);
      if (got_q.size() > 0) chk("rst_post_pc", got_q[0], 32'h200);

      // Randomized traffic against the model.
      lat_fixed = 0;
      lat_rand  = 3;
      for (int i = 0; i < 3000; i++) begin
         pc_valid_i       = ($urandom_range(0, 9) < 7);
         pc_i             = $urandom() & 32'hFFFF_FFFC;
         flush_i          = ($urandom_range(0, 19) == 0);
         instr_ready_i    = ($urandom_range(0, 9) < 6);
         imem_req_ready_i = ($urandom_range(0, 9) < 7);
         tick();
      end
      imem_req_ready_i = 1'b1;
      drain(20);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
